// File: rtl/seq_div_4b_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DIV_W = 4;

    // Step-counter width for a given operand width; never narrower than 1 bit.
    function automatic int cnt_w(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

    localparam int DIV_CNT_W = cnt_w(DIV_W);

endpackage

// File: rtl/seq_div_4b_if.sv
// Launch/result bundle of the sequential divider; master drives operands, slave returns results.
interface seq_div_4b_if
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_W
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start, a, b,
        input  quotient, remainder, busy, done, div_by_zero
    );

    modport slave (
        input  start, a, b,
        output quotient, remainder, busy, done, div_by_zero
    );

endinterface

// File: rtl/seq_div_4b_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract b through a ripple borrow chain.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic [WIDTH:0]   r,
    input  logic             dbit,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   r_nx,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] b_inv;
    logic [WIDTH:0] diff;
    logic           no_borrow;
    logic           unused_r_msb;

    // R is always below b before the shift, so its top bit carries no information here.
    assign unused_r_msb = r[WIDTH];
    assign shifted      = {r[WIDTH-1:0], dbit};
    assign b_inv        = ~{1'b0, b};

    always_comb begin : sub_chain
        logic c;
        c    = 1'b1;
        diff = '0;
        for (int i = 0; i <= WIDTH; i++) begin
            diff[i] = shifted[i] ^ b_inv[i] ^ c;
            c       = (shifted[i] & b_inv[i]) | (c & (shifted[i] ^ b_inv[i]));
        end
        no_borrow = c;
    end

    assign q_bit = no_borrow;
    assign r_nx  = no_borrow ? diff : shifted;

endmodule

// File: rtl/seq_div_4b.sv
// Sequential restoring divider, one quotient bit per clock, MSB first.
// Optional DIV_ZERO_FLAG_EN: divide-by-zero short-circuits to DONE and raises div_by_zero.
module seq_div_4b
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic         clk,
    input  logic         rst,
    seq_div_4b_if.slave  bus
);

    localparam int CNT_W = cnt_w(WIDTH);

    state_t           state;
    state_t           state_nx;
    logic             load;
    logic             step_en;
    logic             finish;
    logic             zero_skip;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH:0]   r_q;
    logic [WIDTH-1:0] q_w;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;

    logic [WIDTH:0]   r_nx;
    logic             q_bit;

    div_step #(.WIDTH(WIDTH)) u_step (
        .r     (r_q),
        .dbit  (a_q[WIDTH-1]),
        .b     (b_q),
        .r_nx  (r_nx),
        .q_bit (q_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        load      = 1'b0;
        step_en   = 1'b0;
        finish    = 1'b0;
        zero_skip = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load = 1'b1;
`ifdef DIV_ZERO_FLAG_EN
                    if (bus.b == '0) begin
                        zero_skip = 1'b1;
                        state_nx  = DONE;
                    end else begin
                        state_nx  = RUN;
                    end
`else
                    state_nx = RUN;
`endif
                end
            end
            RUN: begin
                step_en = 1'b1;
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    finish   = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Dividend is consumed from a_q's MSB while quotient bits enter q_w's LSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q         <= '0;
            b_q         <= '0;
            r_q         <= '0;
            q_w         <= '0;
            cnt         <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            if (load) begin
                a_q <= bus.a;
                b_q <= bus.b;
                r_q <= '0;
                q_w <= '0;
                cnt <= '0;
            end
            if (step_en) begin
                a_q <= {a_q[WIDTH-2:0], 1'b0};
                r_q <= r_nx;
                q_w <= {q_w[WIDTH-2:0], q_bit};
                cnt <= cnt + CNT_W'(1);
            end
            if (finish) begin
                quotient_q  <= {q_w[WIDTH-2:0], q_bit};
                remainder_q <= r_nx[WIDTH-1:0];
            end
            if (zero_skip) begin
                quotient_q  <= '1;
                remainder_q <= bus.a;
            end
        end
    end

`ifdef DIV_ZERO_FLAG_EN
    logic dbz_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)            dbz_q <= 1'b0;
        else if (zero_skip) dbz_q <= 1'b1;
        else if (finish)    dbz_q <= 1'b0;
    end

    assign bus.div_by_zero = dbz_q;
`else
    assign bus.div_by_zero = 1'b0;
`endif

    assign bus.quotient  = quotient_q;
    assign bus.remainder = remainder_q;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);

endmodule

// File: tb/tb_seq_div_4b.sv
// Self-checking bench for seq_div_4b against an arithmetic (/, %) reference model.
module tb_seq_div_4b;

    localparam int W = 4;
`ifdef DIV_ZERO_FLAG_EN
    localparam bit FLAG = 1'b1;
`else
    localparam bit FLAG = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_div_4b_if #(.WIDTH(W)) bus ();

    seq_div_4b #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    function automatic int ref_q(input int av, input int bv);
        return (bv == 0) ? ((1 << W) - 1) : (av / bv);
    endfunction

    function automatic int ref_r(input int av, input int bv);
        return (bv == 0) ? av : (av % bv);
    endfunction

    function automatic int ref_lat(input int bv);
        return (FLAG && bv == 0) ? 0 : W;
    endfunction

    function automatic int ref_dbz(input int bv);
        return (FLAG && bv == 0) ? 1 : 0;
    endfunction

    // Launches one division and observes it; lat counts falling edges after the launch edge until done (-1 = never).
    task automatic run_op(input int av, input int bv, output int lat, output int busy_cyc);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = W'(av);
        bus.b     = W'(bv);
        @(posedge clk);
        #1 bus.start = 1'b0;
        lat      = -1;
        busy_cyc = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.busy) busy_cyc++;
            if (bus.done && lat < 0) lat = k;
            if (!bus.busy) break;
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.quotient, bus.remainder, bus.busy, bus.done, bus.div_by_zero} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got q=%0d r=%0d busy=%0b done=%0b dbz=%0b want all 0",
                     bus.quotient, bus.remainder, bus.busy, bus.done, bus.div_by_zero);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset got busy=%0b done=%0b want 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic check_op(input string name, input int av, input int bv);
        int lat, bc;
        run_op(av, bv, lat, bc);
        checks++;
        if (bus.quotient !== W'(ref_q(av, bv)) || bus.remainder !== W'(ref_r(av, bv))) begin
            errors++;
            $display("FAIL %s_result %0d/%0d got q=%0d r=%0d want q=%0d r=%0d",
                     name, av, bv, bus.quotient, bus.remainder, ref_q(av, bv), ref_r(av, bv));
        end
        checks++;
        if (lat != ref_lat(bv)) begin
            errors++;
            $display("FAIL %s_latency %0d/%0d got %0d want %0d", name, av, bv, lat, ref_lat(bv));
        end
        checks++;
        if (bc != ref_lat(bv) + 1) begin
            errors++;
            $display("FAIL %s_busy_cycles %0d/%0d got %0d want %0d", name, av, bv, bc, ref_lat(bv) + 1);
        end
        checks++;
        if (int'(bus.div_by_zero) != ref_dbz(bv)) begin
            errors++;
            $display("FAIL %s_dbz %0d/%0d got %0b want %0d", name, av, bv, bus.div_by_zero, ref_dbz(bv));
        end
    endtask

    task automatic test_basic();
        check_op("basic", 13, 3);
    endtask

    task automatic test_patterns();
        check_op("small_over_big", 9, 12);
        check_op("div_by_one", 15, 1);
        for (int i = 0; i < 25; i++) begin
            int av, bv;
            av = int'($urandom_range(0, (1 << W) - 1));
            bv = int'($urandom_range(0, (1 << W) - 1));
            check_op("random", av, bv);
        end
    endtask

    task automatic test_div_zero();
        check_op("div_zero", 7, 0);
        check_op("after_zero", 11, 2);
    endtask

    task automatic test_ignore_start();
        int dones;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = W'(13);
        bus.b     = W'(3);
        @(posedge clk);
        #1 bus.start = 1'b0;
        dones = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.start = 1'b1;
                bus.a     = W'(6);
                bus.b     = W'(2);
            end else if (k == 2) begin
                bus.start = 1'b0;
            end
            if (bus.done) dones++;
        end
        checks++;
        if (bus.quotient !== W'(4) || bus.remainder !== W'(1)) begin
            errors++;
            $display("FAIL ignore_start_result got q=%0d r=%0d want q=4 r=1", bus.quotient, bus.remainder);
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL ignore_start_done_count got %0d want 1", dones);
        end
    endtask

    task automatic test_reset_mid();
        int dones;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = W'(14);
        bus.b     = W'(4);
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.quotient, bus.remainder, bus.busy, bus.done, bus.div_by_zero} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs got q=%0d r=%0d busy=%0b done=%0b dbz=%0b want all 0",
                     bus.quotient, bus.remainder, bus.busy, bus.done, bus.div_by_zero);
        end
        dones = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.done || bus.busy) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL reset_mid_no_done got %0d active cycles want 0", dones);
        end
        check_op("after_reset", 14, 4);
    endtask

    task automatic test_back_to_back();
        int idx[$];
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = W'(10);
        bus.b     = W'(3);
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (bus.done) begin
                idx.push_back(n);
                checks++;
                if (bus.quotient !== W'(3) || bus.remainder !== W'(1)) begin
                    errors++;
                    $display("FAIL b2b_result at %0d got q=%0d r=%0d want q=3 r=1", n, bus.quotient, bus.remainder);
                end
            end
        end
        bus.start = 1'b0;
        checks++;
        if (idx.size() < 4) begin
            errors++;
            $display("FAIL b2b_pulse_count got %0d want at least 4", idx.size());
        end
        for (int i = 1; i < idx.size(); i++) begin
            checks++;
            if (idx[i] - idx[i-1] != W + 2) begin
                errors++;
                $display("FAIL b2b_interval got %0d want %0d", idx[i] - idx[i-1], W + 2);
            end
        end
        for (int k = 0; k < 20 && bus.busy; k++) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain got busy=%0b want 0", bus.busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_patterns();
        test_div_zero();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
